// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared state encoding and instruction IDs for pc_sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WAIT   = 3'd4,
    S_LINK   = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [5:0] ID_BEQ  = 6'd15;
  localparam logic [5:0] ID_BNE  = 6'd16;
  localparam logic [5:0] ID_BGT  = 6'd17;
  localparam logic [5:0] ID_BGTE = 6'd18;
  localparam logic [5:0] ID_BLE  = 6'd19;
  localparam logic [5:0] ID_BLEQ = 6'd20;
  localparam logic [5:0] ID_J    = 6'd21;
  localparam logic [5:0] ID_JR   = 6'd22;
  localparam logic [5:0] ID_JAL  = 6'd23;
  localparam logic [5:0] ID_HALT = 6'd63;

  localparam logic [4:0] LINK_REG = 5'd31;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_branch_resolve.sv
// ============================================================================
// Module      : branch_resolve
// Description : Combinational branch/jump condition, target and alignment.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module branch_resolve
  import pc_seq_pkg::*;
(
  input  logic [5:0]  id,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output logic        is_branch,
  output logic        taken,
  output logic [31:0] target,
  output logic        misaligned
);

  logic [31:0] rel_target;

  assign rel_target = pc + 32'd4 + imm;

  always_comb begin
    is_branch = 1'b1;
    taken     = 1'b0;
    target    = rel_target;
    case (id)
      ID_BEQ:  taken = (a == b);
      ID_BNE:  taken = (a != b);
      ID_BGT:  taken = ($signed(a) >  $signed(b));
      ID_BGTE: taken = ($signed(a) >= $signed(b));
      ID_BLE:  taken = ($signed(a) <  $signed(b));
      ID_BLEQ: taken = ($signed(a) <= $signed(b));
      ID_J: begin
        taken  = 1'b1;
        target = imm;
      end
      ID_JR: begin
        taken  = 1'b1;
        target = a;
      end
      ID_JAL: begin
        taken  = 1'b1;
        target = imm;
      end
      default: is_branch = 1'b0;
    endcase
  end

  // Only a redirect can fault; a not-taken branch falls through to pc+4.
  assign misaligned = is_branch && taken && (target[1:0] != 2'b00);

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Multi-cycle fetch/decode/execute PC controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  input  logic [5:0]  id,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] imm,
  output logic        exec_start,
  input  logic        exec_done,
  output logic        link_we,
  output logic [4:0]  link_addr,
  output logic [31:0] link_data,
  output logic [31:0] pc,
  output logic        taken,
  output logic        fault,
  output logic [31:0] retired
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] retired_q, retired_d;
  logic        fault_q, fault_d;
  logic [5:0]  id_q, id_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] imm_q, imm_d;

  logic        br_is_branch;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_misaligned;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  branch_resolve u_resolve (
    .id         (id_q),
    .a          (a_q),
    .b          (b_q),
    .imm        (imm_q),
    .pc         (pc_q),
    .is_branch  (br_is_branch),
    .taken      (br_taken),
    .target     (br_target),
    .misaligned (br_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 32'd0;
      retired_q <= 32'd0;
      fault_q   <= 1'b0;
      id_q      <= 6'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      imm_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      id_q      <= id_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    id_d      = id_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        id_d    = id;
        a_d     = op_a;
        b_d     = op_b;
        imm_d   = imm;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (id_q == ID_HALT) begin
          retired_d = retired_q + 32'd1;
          state_d   = S_HALT;
        end else if (id_q == ID_JAL) begin
          state_d = S_LINK;
        end else if (br_is_branch) begin
          if (br_misaligned) begin
            fault_d = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d      = br_taken ? br_target : pc_plus4;
            retired_d = retired_q + 32'd1;
            state_d   = S_FETCH;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (exec_done) begin
          pc_d      = pc_plus4;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      S_LINK: begin
        if (br_misaligned) begin
          fault_d = 1'b1;
          state_d = S_HALT;
        end else begin
          pc_d      = br_target;
          retired_d = retired_q + 32'd1;
          state_d   = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from registered state so they line up with the pc update edge.
  always_comb begin
    imem_req   = (state_q == S_FETCH);
    exec_start = (state_q == S_EXEC) && !br_is_branch && (id_q != ID_HALT);
    link_we    = (state_q == S_LINK) && !br_misaligned;
    taken      = link_we ||
                 ((state_q == S_EXEC) && br_is_branch && (id_q != ID_JAL) &&
                  br_taken && !br_misaligned);
    link_data  = link_we ? pc_plus4 : 32'd0;
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign retired   = retired_q;
  assign fault     = fault_q;
  assign link_addr = LINK_REG;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Scoreboard bench for pc_sequencer with directed and random programs.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, imem_ack, exec_done;
  logic [31:0] imem_rdata, op_a, op_b, imm;
  logic [5:0]  id;
  logic        imem_req, exec_start, link_we, taken, fault;
  logic [31:0] imem_addr, ir, link_data, pc, retired;
  logic [4:0]  link_addr;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir(ir), .id(id), .op_a(op_a), .op_b(op_b), .imm(imm),
    .exec_start(exec_start), .exec_done(exec_done),
    .link_we(link_we), .link_addr(link_addr), .link_data(link_data),
    .pc(pc), .taken(taken), .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam int E_FETCH = 0, E_TAKEN = 1, E_LINK = 2, E_EXEC = 3;
  localparam int K_EXEC = 0, K_TAKEN = 1, K_NT = 2, K_JAL = 3, K_FAULT = 4, K_HALT = 5;

  typedef struct {
    int          kind;
    logic [31:0] v;
    logic [31:0] w;
  } ev_t;

  ev_t         sb[$];
  int          n_vec = 0, n_err = 0;
  int          cyc = 0;
  bit          prev_req = 1'b0;
  logic [31:0] m_pc = 32'd0, m_ret = 32'd0;
  int          m_next_fetch = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input logic [31:0] v, input logic [31:0] w);
    ev_t e;
    e.kind = k; e.v = v; e.w = w;
    sb.push_back(e);
  endtask

  task automatic observe(input int k, input logic [31:0] v, input logic [31:0] w, input string nm);
    ev_t e;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s unexpected: got %h/%h, expected no event (t=%0t)", nm, v, w, $time);
    end else begin
      e = sb.pop_front();
      chk({nm, "_kind"}, k, e.kind);
      chk({nm, "_v"}, v, e.v);
      chk({nm, "_w"}, w, e.w);
    end
  endtask

  // Monitor: samples just after the falling edge so driver pushes land first.
  always @(negedge clk) begin
    #1;
    if (rst) prev_req = 1'b0;
    else begin
      if (imem_req && !prev_req) observe(E_FETCH, imem_addr, retired, "fetch");
      if (link_we)    observe(E_LINK, link_data, {27'd0, link_addr}, "link");
      if (taken)      observe(E_TAKEN, pc, 32'd0, "taken");
      if (exec_start) observe(E_EXEC, pc, 32'd0, "exec_start");
      prev_req = imem_req;
    end
  end

  // Reference: what the architecture says one instruction does.
  function automatic void model(input logic [5:0] iid, input logic [31:0] p, a, b, im,
                                output int k, output logic [31:0] npc);
    logic [31:0] tgt;
    bit tk, br;
    tk = 1'b0; br = 1'b1; tgt = p + 32'd4 + im;
    case (iid)
      6'd15: tk = (a == b);
      6'd16: tk = (a != b);
      6'd17: tk = ($signed(a) > $signed(b));
      6'd18: tk = ($signed(a) >= $signed(b));
      6'd19: tk = ($signed(a) < $signed(b));
      6'd20: tk = ($signed(a) <= $signed(b));
      6'd21: begin tk = 1'b1; tgt = im; end
      6'd22: begin tk = 1'b1; tgt = a; end
      6'd23: begin tk = 1'b1; tgt = im; end
      default: br = 1'b0;
    endcase
    if (iid == 6'd63)                        begin k = K_HALT;  npc = p; end
    else if (!br)                            begin k = K_EXEC;  npc = p + 32'd4; end
    else if (tk && (tgt % 4 != 0))           begin k = K_FAULT; npc = p; end
    else if (iid == 6'd23)                   begin k = K_JAL;   npc = tgt; end
    else if (tk)                             begin k = K_TAKEN; npc = tgt; end
    else                                     begin k = K_NT;    npc = p + 32'd4; end
  endfunction

  task automatic abort(input string why);
    n_err++;
    $display("FAIL %s: timeout waiting on DUT", why);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  endtask

  task automatic wait_req();
    for (int i = 0; i < 50; i++) begin
      if (imem_req) return;
      @(negedge clk);
    end
    if (!imem_req) abort("wait_imem_req");
  endtask

  task automatic fetch_decode(input logic [5:0] iid, input logic [31:0] a, b, im,
                              input int ack_dly, output int t0);
    logic [31:0] word;
    wait_req();
    if (m_next_fetch >= 0) chk("fetch_latency", cyc, m_next_fetch);
    repeat (ack_dly) begin
      @(negedge clk);
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_held", imem_addr, m_pc);
    end
    word = $urandom;
    imem_rdata = word; imem_ack = 1'b1;
    id = iid; op_a = a; op_b = b; imm = im;
    t0 = cyc;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("ir_load", ir, word);
    chk("req_drop", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic wait_exec_start();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (exec_start) return;
    end
    abort("wait_exec_start");
  endtask

  task automatic run_instr(input logic [5:0] iid, input logic [31:0] a, b, im,
                           input int ack_dly, input int done_dly);
    int k, t0;
    logic [31:0] npc;
    model(iid, m_pc, a, b, im, k, npc);
    push(E_FETCH, m_pc, m_ret);
    case (k)
      K_TAKEN: push(E_TAKEN, m_pc, 32'd0);
      K_JAL: begin push(E_LINK, m_pc + 32'd4, 32'd31); push(E_TAKEN, m_pc, 32'd0); end
      K_EXEC:  push(E_EXEC, m_pc, 32'd0);
      default: ;
    endcase
    fetch_decode(iid, a, b, im, ack_dly, t0);
    case (k)
      K_EXEC: begin
        wait_exec_start();
        @(negedge clk);
        repeat (done_dly) @(negedge clk);
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        m_next_fetch = t0 + 4 + done_dly;
      end
      K_TAKEN, K_NT: m_next_fetch = t0 + 3;
      K_JAL:         m_next_fetch = t0 + 4;
      default:       m_next_fetch = -1;
    endcase
    if (k != K_FAULT) m_ret = m_ret + 32'd1;
    m_pc = npc;
    if (k == K_HALT || k == K_FAULT) begin
      repeat (4) @(negedge clk);
      chk("halt_fault", {31'd0, fault}, (k == K_FAULT) ? 32'd1 : 32'd0);
      chk("halt_pc", pc, m_pc);
      chk("halt_retired", retired, m_ret);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("halt_ignores_start", {31'd0, imem_req}, 32'd0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    @(negedge clk);
    chk("rst_pc", pc, 32'd0);
    chk("rst_ir", ir, 32'd0);
    chk("rst_retired", retired, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_strobes", {28'd0, imem_req, exec_start, link_we, taken}, 32'd0);
    chk("rst_link_data", link_data, 32'd0);
    chk("rst_link_addr", {27'd0, link_addr}, 32'd31);
    chk("sb_drained", sb.size(), 32'd0);
    rst = 1'b0;
    sb.delete();
    m_pc = 32'd0; m_ret = 32'd0; m_next_fetch = -1;
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    int t0;
    logic [5:0]  rid;
    logic [31:0] ra, rb, rim, tmp;
    rst = 1'b1; start = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    imem_rdata = 32'd0; id = 6'd0; op_a = 32'd0; op_b = 32'd0; imm = 32'd0;
    repeat (2) @(negedge clk);
    do_reset();

    // Slow fetch, beq/bne, signed compares, jal, not-taken misaligned branch.
    kick();
    run_instr(ID_J,    32'd0, 32'd0, 32'h10, 2, 0);
    run_instr(ID_BEQ,  32'd5, 32'd5, 32'd8, 0, 0);
    run_instr(ID_J,    32'd0, 32'd0, 32'h10, 0, 0);
    run_instr(ID_BNE,  32'd5, 32'd5, 32'd8, 1, 0);
    run_instr(ID_BGT,  32'hFFFF_FFFF, 32'd1, 32'd8, 0, 0);
    run_instr(ID_BLE,  32'hFFFF_FFFF, 32'd1, 32'd8, 0, 0);
    run_instr(ID_J,    32'd0, 32'd0, 32'h20, 0, 0);
    run_instr(ID_JAL,  32'd0, 32'd0, 32'h100, 0, 0);
    run_instr(ID_BNE,  32'd7, 32'd7, 32'd2, 0, 0);
    run_instr(ID_HALT, 32'd0, 32'd0, 32'd0, 0, 0);
    do_reset();

    // Misaligned jr and jal both fault without side effects.
    kick();
    run_instr(ID_J,  32'd0, 32'd0, 32'h40, 0, 0);
    run_instr(ID_JR, 32'h102, 32'd0, 32'd0, 0, 0);
    do_reset();
    kick();
    run_instr(ID_JAL, 32'd0, 32'd0, 32'h102, 0, 0);
    do_reset();

    // PC wrap through a long exec, then reset while waiting on exec_done.
    kick();
    run_instr(ID_J,    32'd0, 32'd0, 32'hFFFF_FFFC, 0, 0);
    run_instr(6'd3,    32'd0, 32'd0, 32'd0, 0, 3);
    run_instr(ID_HALT, 32'd0, 32'd0, 32'd0, 0, 0);
    do_reset();
    kick();
    run_instr(ID_J, 32'd0, 32'd0, 32'hFFFF_FFFC, 0, 0);
    push(E_FETCH, m_pc, m_ret);
    push(E_EXEC, m_pc, 32'd0);
    fetch_decode(6'd3, 32'd0, 32'd0, 32'd0, 0, t0);
    wait_exec_start();
    @(negedge clk);
    do_reset();

    // Random program of aligned-target instructions ending in HALT.
    kick();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 4) begin
        tmp = $urandom_range(0, 53);
        rid = (tmp < 15) ? tmp[5:0] : 6'(tmp + 32'd9);
      end else begin
        rid = 6'(15 + $urandom_range(0, 8));
      end
      ra = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) ra = -ra;
      rb = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) rb = -rb;
      rim = 32'($urandom_range(0, 64)) * 32'd4 - 32'd128;
      if (rid == ID_JR) ra = $urandom & 32'hFFFF_FFFC;
      if (rid == ID_J || rid == ID_JAL) rim = $urandom & 32'hFFFF_FFFC;
      run_instr(rid, ra, rb, rim, $urandom_range(0, 2), $urandom_range(0, 3));
    end
    run_instr(ID_HALT, 32'd0, 32'd0, 32'd0, 0, 0);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter controller for the processor core. Owns the PC register and the fetch/decode/execute sequence. Resolves branch and jump instructions (IDs 15–23) through a combinational resolve sub-block, and hands every other instruction to the datapath via an exec start/done handshake. Sits between instruction memory, the decoder/register file and the ALU datapath.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; leaves IDLE.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc.
- imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle.
- imem_rdata  in  32  instruction word.
- ir  out  32  latched instruction, drives the decoder.
- id  in  6  instruction ID from the decoder, valid during DECODE.
- op_a, op_b  in  32  register operands, valid during DECODE.
- imm  in  32  sign-extended constant, valid during DECODE.
- exec_start  out  1  one-cycle pulse for non-branch instructions.
- exec_done  in  1  datapath finished.
- link_we  out  1  register-file write strobe for jal.
- link_addr  out  5  constant 31.
- link_data  out  32  return address.
- pc  out  32  current PC.
- taken  out  1  one-cycle pulse when the PC is redirected.
- fault  out  1  sticky misaligned-target flag.
- retired  out  32  retired-instruction counter.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WAIT, LINK, HALT.
- IDLE: waits for start=1, then goes to FETCH.
- FETCH: imem_req=1 with imem_addr=pc, both held until imem_ack=1. On that edge ir<=imem_rdata and the state goes to DECODE.
- DECODE: one cycle. Registers id, op_a, op_b and imm internally, then goes to EXEC.
- EXEC, id=63 (HALT): retired+1, go to HALT. No fault.
- EXEC, id 15–22, branch taken:
  - beq: a==b. bne: a!=b. bgt: a>b. bgte: a>=b. ble: a<b. bleq: a<=b. All comparisons signed.
  - Target for these six: pc+4+imm.
  - j: target=imm. jr: target=op_a. Both are always taken.
  - Action: pc<=target, taken=1, retired+1, go to FETCH.
- EXEC, id 15–22, branch not taken: pc<=pc+4, retired+1, go to FETCH.
- EXEC, id 23 (jal): go to LINK.
- LINK: link_we=1 for one cycle with link_data=pc+4. Same cycle: pc<=imm, taken=1, retired+1, go to FETCH.
- EXEC, any other id: exec_start=1 for exactly one cycle, go to WAIT.
- WAIT: on exec_done=1, pc<=pc+4, retired+1, go to FETCH.
- Fault: a redirected target with target[1:0]!=0 sets fault=1. pc keeps the faulting instruction's address, no retire, no taken, no link write, go to HALT. Not-taken branches never fault.
- HALT: all strobes 0. Only rst exits HALT.
- All PC arithmetic is modulo 2^32: pc+4 from 0xFFFF_FFFC gives 0. retired wraps.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, ir=0, retired=0, fault=0. imem_req, exec_start, link_we and taken are 0. link_data=0, link_addr=31.
- Reset has priority over every state, including mid-FETCH and mid-WAIT. Outputs take reset values from the next cycle.
- imem_ack is honoured only in FETCH. An ack in the first FETCH cycle is legal (1-cycle fetch).
- exec_done is sampled only in WAIT, so the exec path has at least one WAIT cycle.
- Cycle counts with 1-cycle fetch:
  - branch/jump: 3 cycles
  - jal: 4 cycles
  - non-branch: 3 + WAIT cycles
- start is ignored outside IDLE.
- taken and link_we are asserted in the same cycle the pc register updates.

## Structure
- Package pc_seq_pkg holds:
  - state enum
  - ID constants: ID_BEQ=15, ID_BNE=16, ID_BGT=17, ID_BGTE=18, ID_BLE=19, ID_BLEQ=20, ID_J=21, ID_JR=22, ID_JAL=23, ID_HALT=63
  - LINK_REG=31
- Sub-module branch_resolve: purely combinational (id, a, b, imm, pc) -> (is_branch, taken, target, misaligned).
- The FSM, pc register and retired counter live in pc_sequencer.

## Test plan
1. Reset, start, imem_ack delayed 2 cycles -> imem_req=1 with imem_addr=0 stable for 3 cycles; ir loaded on the ack edge.
2. beq at pc=0x10, a=b=5, imm=8 -> pc=0x1C, taken pulse. Same operands with bne -> pc=0x14, no taken pulse, retired incremented.
3. bgt with a=0xFFFF_FFFF, b=1 -> not taken (signed). ble with the same operands -> taken.
4. jal at pc=0x20, imm=0x100 -> one link_we cycle with link_addr=31, link_data=0x24; next fetch at imem_addr=0x100.
5. jr at pc=0x40 with a=0x102 -> fault=1, HALT, pc=0x40, imem_req stays 0; rst clears fault and returns to IDLE.
6. Non-branch id 3 at pc=0xFFFF_FFFC, exec_done after 4 cycles -> single exec_start pulse, pc wraps to 0. Repeat with rst in WAIT -> all outputs at reset values the next cycle.
